board_renderer: RTL and testbench



---
 rtl/board_renderer.sv | 122 ++++++++++++
 tb/tb_board_renderer.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/board_renderer.sv
// Renders the 10x10 game board, cursor, turns bar and win/lose effects from VGA counters.
// Two-stage pipeline: rgb/in_grid are valid exactly 2 clk after hcount/vcount/bright.
module board_renderer #(
  parameter int GRID_X0      = 120,
  parameter int GRID_Y0      = 40,
  parameter int CELL         = 40,
  parameter int BLINK_FRAMES = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [9:0]   hcount,
  input  logic [9:0]   vcount,
  input  logic         bright,
  input  logic [199:0] cell_status_flat,
  input  logic [3:0]   sprite_row,
  input  logic [3:0]   sprite_col,
  input  logic [4:0]   turns_left,
  input  logic         win,
  input  logic         lose,
  output logic [11:0]  rgb,
  output logic         in_grid
);

  localparam int GW = 10 * CELL;
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam int BAR_Y0 = GRID_Y0 + GW + 8;

  logic [3:0] col_n, row_n, col_q, row_q, tl;
  logic [5:0] xoff_n, yoff_n, xoff_q, yoff_q;
  logic       in_x_n, in_y_n, in_grid_q, bright_q, bar_n, bar_q;
  logic       at_origin, at_origin_d, tick, blink_on;
  logic [BW-1:0] blink_cnt;

  // Cell index from a comparator chain against the cell boundaries.
  always_comb begin
    col_n = '0;
    row_n = '0;
    for (int k = 1; k < 10; k++) begin
      if (int'(hcount) >= GRID_X0 + k * CELL) col_n = col_n + 4'd1;
      if (int'(vcount) >= GRID_Y0 + k * CELL) row_n = row_n + 4'd1;
    end
    xoff_n = 6'(int'(hcount) - GRID_X0 - int'(col_n) * CELL);
    yoff_n = 6'(int'(vcount) - GRID_Y0 - int'(row_n) * CELL);
    in_x_n = (int'(hcount) >= GRID_X0) && (int'(hcount) < GRID_X0 + GW);
    in_y_n = (int'(vcount) >= GRID_Y0) && (int'(vcount) < GRID_Y0 + GW);
    tl     = (turns_left > 5'd15) ? 4'd15 : turns_left[3:0];
    bar_n  = (int'(vcount) >= BAR_Y0) && (int'(vcount) < BAR_Y0 + 8) &&
             (int'(hcount) >= GRID_X0) && (int'(hcount) < GRID_X0 + int'(tl) * 8);
  end

  assign at_origin = (hcount == 10'd0) && (vcount == 10'd0);
  assign tick      = at_origin & ~at_origin_d;

  logic [7:0]  sbase;
  logic [1:0]  status;
  logic        ring, cursor_cell;
  logic [11:0] rgb_n;

  always_comb begin
    sbase       = 8'((int'(row_q) * 10 + int'(col_q)) * 2);
    status      = cell_status_flat[sbase +: 2];
    ring        = (xoff_q == 6'd1) || (xoff_q == 6'd2) ||
                  (xoff_q == 6'(CELL - 2)) || (xoff_q == 6'(CELL - 1)) ||
                  (yoff_q == 6'd1) || (yoff_q == 6'd2) ||
                  (yoff_q == 6'(CELL - 2)) || (yoff_q == 6'(CELL - 1));
    // row_q/col_q never exceed 9, so an off-board sprite never matches.
    cursor_cell = (row_q == sprite_row) && (col_q == sprite_col);
    rgb_n       = 12'h000;
    if (!bright_q)
      rgb_n = 12'h000;
    else if (in_grid_q && (xoff_q == 6'd0 || yoff_q == 6'd0))
      rgb_n = 12'hFFF;
    else if (in_grid_q && cursor_cell && blink_on && !win && !lose && ring)
      rgb_n = 12'hFF0;
    else if (in_grid_q) begin
      case (status)
        2'b00:   rgb_n = lose ? 12'h400 : 12'h008;
        2'b01:   rgb_n = 12'h888;
        2'b10:   rgb_n = 12'hF00;
        default: rgb_n = (win && blink_on) ? 12'hF80 : 12'h840;
      endcase
    end else if (bar_q)
      rgb_n = 12'h0F0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      col_q       <= '0;
      row_q       <= '0;
      xoff_q      <= '0;
      yoff_q      <= '0;
      in_grid_q   <= 1'b0;
      bright_q    <= 1'b0;
      bar_q       <= 1'b0;
      rgb         <= 12'h000;
      in_grid     <= 1'b0;
      at_origin_d <= 1'b0;
      blink_cnt   <= '0;
      blink_on    <= 1'b1;
    end else begin
      col_q       <= col_n;
      row_q       <= row_n;
      xoff_q      <= xoff_n;
      yoff_q      <= yoff_n;
      in_grid_q   <= in_x_n & in_y_n;
      bright_q    <= bright;
      bar_q       <= bar_n;
      rgb         <= rgb_n;
      in_grid     <= in_grid_q;
      at_origin_d <= at_origin;
      if (tick) begin
        if (blink_cnt == BW'(BLINK_FRAMES - 1)) begin
          blink_cnt <= '0;
          blink_on  <= ~blink_on;
        end else begin
          blink_cnt <= blink_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_board_renderer.sv
// Directed bench for board_renderer: each task drives a scenario and checks rgb/in_grid inline.
module tb_board_renderer;
  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [9:0]   hcount = 10'd1;
  logic [9:0]   vcount = 10'd1;
  logic         bright = 1'b1;
  logic [199:0] cell_status_flat = '0;
  logic [3:0]   sprite_row = 4'd9;
  logic [3:0]   sprite_col = 4'd9;
  logic [4:0]   turns_left = 5'd0;
  logic         win = 1'b0;
  logic         lose = 1'b0;
  logic [11:0]  rgb;
  logic         in_grid;

  int checks = 0;
  int errors = 0;

  board_renderer dut (
    .clk(clk), .reset(reset), .hcount(hcount), .vcount(vcount), .bright(bright),
    .cell_status_flat(cell_status_flat), .sprite_row(sprite_row), .sprite_col(sprite_col),
    .turns_left(turns_left), .win(win), .lose(lose), .rgb(rgb), .in_grid(in_grid)
  );

  always #5 clk = ~clk;

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  // Apply a pixel and wait out the 2-clk pipeline; sample 1 time unit after the edge.
  task automatic show(input int h, input int v);
    hcount = 10'(h);
    vcount = 10'(v);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic frame_tick(input int hold);
    hcount = 10'd0;
    vcount = 10'd0;
    repeat (hold) @(posedge clk);
    #1;
    hcount = 10'd1;
    vcount = 10'd1;
    @(posedge clk); #1;
  endtask

  task automatic set_cell(input int r, input int c, input logic [1:0] s);
    cell_status_flat[(r*10+c)*2 +: 2] = s;
  endtask

  task automatic test_reset();
    hcount = 10'd140; vcount = 10'd60; bright = 1'b1;
    repeat (3) @(posedge clk); #1;
    checks++;
    if (rgb !== 12'h000 || in_grid !== 1'b0) begin
      errors++;
      $display("FAIL reset_hold: rgb=%h in_grid=%b, required rgb=000 in_grid=0", rgb, in_grid);
    end
    reset = 1'b0;
    show(140, 60);
    checks++;
    if (rgb !== 12'h008) begin
      errors++;
      $display("FAIL pre_midreset: rgb=%h, required 008", rgb);
    end
    reset = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (rgb !== 12'h000 || in_grid !== 1'b0) begin
      errors++;
      $display("FAIL midframe_reset: rgb=%h in_grid=%b, required 000/0", rgb, in_grid);
    end
    reset = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (rgb !== 12'h000) begin
      errors++;
      $display("FAIL resume_1clk: rgb=%h, required 000", rgb);
    end
    @(posedge clk); #1;
    checks++;
    if (rgb !== 12'h008 || in_grid !== 1'b1) begin
      errors++;
      $display("FAIL resume_2clk: rgb=%h in_grid=%b, required 008/1", rgb, in_grid);
    end
  endtask

  task automatic test_basic();
    bright = 1'b1;
    show(140, 60);
    checks++;
    if (rgb !== 12'h008 || in_grid !== 1'b1) begin
      errors++;
      $display("FAIL basic_unknown: rgb=%h in_grid=%b, required 008/1", rgb, in_grid);
    end
    bright = 1'b0;
    show(140, 60);
    checks++;
    if (rgb !== 12'h000 || in_grid !== 1'b1) begin
      errors++;
      $display("FAIL basic_dark: rgb=%h in_grid=%b, required 000/1", rgb, in_grid);
    end
    bright = 1'b1;
  endtask

  task automatic test_status();
    do_reset();
    set_cell(1, 2, 2'b10);
    show(210, 90);
    checks++;
    if (rgb !== 12'hF00) begin
      errors++;
      $display("FAIL status_hit: rgb=%h, required F00", rgb);
    end
    // Stage 2 reads the live status vector, so a change shows after one clock.
    set_cell(1, 2, 2'b01);
    @(posedge clk); #1;
    checks++;
    if (rgb !== 12'h888) begin
      errors++;
      $display("FAIL status_miss_1clk: rgb=%h, required 888", rgb);
    end
    set_cell(1, 2, 2'b11);
    show(210, 90);
    checks++;
    if (rgb !== 12'h840) begin
      errors++;
      $display("FAIL status_sunk: rgb=%h, required 840", rgb);
    end
    win = 1'b1;
    show(210, 90);
    checks++;
    if (rgb !== 12'hF80) begin
      errors++;
      $display("FAIL win_flash_on: rgb=%h, required F80", rgb);
    end
    for (int i = 0; i < 16; i++) frame_tick(1);
    show(210, 90);
    checks++;
    if (rgb !== 12'h840) begin
      errors++;
      $display("FAIL win_flash_off: rgb=%h, required 840", rgb);
    end
    for (int i = 0; i < 16; i++) frame_tick(1);
    show(210, 90);
    checks++;
    if (rgb !== 12'hF80) begin
      errors++;
      $display("FAIL win_flash_on2: rgb=%h, required F80", rgb);
    end
    win = 1'b0;
    cell_status_flat = '0;
  endtask

  task automatic test_grid_lines();
    int          hs[7]  = '{160, 120, 300, 520, 519, 200, 300};
    int          vs[7]  = '{90,  90,  40,  90,  90,  440, 439};
    logic [11:0] er[7]  = '{12'hFFF, 12'hFFF, 12'hFFF, 12'h000, 12'h008, 12'h000, 12'h008};
    logic        eg[7]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    do_reset();
    for (int i = 0; i < 7; i++) begin
      show(hs[i], vs[i]);
      checks++;
      if (rgb !== er[i] || in_grid !== eg[i]) begin
        errors++;
        $display("FAIL grid_vec%0d (%0d,%0d): rgb=%h in_grid=%b, required %h/%b",
                 i, hs[i], vs[i], rgb, in_grid, er[i], eg[i]);
      end
    end
  endtask

  task automatic test_cursor();
    do_reset();
    sprite_row = 4'd0; sprite_col = 4'd0;
    show(121, 45);
    checks++;
    if (rgb !== 12'hFF0) begin
      errors++;
      $display("FAIL cursor_on: rgb=%h, required FF0", rgb);
    end
    show(125, 45);
    checks++;
    if (rgb !== 12'h008) begin
      errors++;
      $display("FAIL cursor_interior: rgb=%h, required 008", rgb);
    end
    show(159, 78);
    checks++;
    if (rgb !== 12'hFF0) begin
      errors++;
      $display("FAIL cursor_far_edge: rgb=%h, required FF0", rgb);
    end
    // Origin held 4 clk is one tick; 14 more reach the last count before toggling.
    frame_tick(4);
    for (int i = 0; i < 14; i++) frame_tick(1);
    show(121, 45);
    checks++;
    if (rgb !== 12'hFF0) begin
      errors++;
      $display("FAIL cursor_15ticks: rgb=%h, required FF0", rgb);
    end
    frame_tick(1);
    show(121, 45);
    checks++;
    if (rgb !== 12'h008) begin
      errors++;
      $display("FAIL cursor_blink_off: rgb=%h, required 008", rgb);
    end
    sprite_row = 4'd9; sprite_col = 4'd9;
  endtask

  task automatic test_bar();
    int          tls[9] = '{3, 3, 3, 3, 3, 3, 0, 20, 20};
    int          hs[9]  = '{120, 143, 144, 119, 130, 130, 120, 239, 240};
    int          vs[9]  = '{448, 448, 448, 448, 455, 456, 448, 450, 450};
    logic [11:0] er[9]  = '{12'h0F0, 12'h0F0, 12'h000, 12'h000, 12'h0F0,
                            12'h000, 12'h000, 12'h0F0, 12'h000};
    do_reset();
    for (int i = 0; i < 9; i++) begin
      turns_left = 5'(tls[i]);
      show(hs[i], vs[i]);
      checks++;
      if (rgb !== er[i] || in_grid !== 1'b0) begin
        errors++;
        $display("FAIL bar_vec%0d (tl=%0d,%0d,%0d): rgb=%h in_grid=%b, required %h/0",
                 i, tls[i], hs[i], vs[i], rgb, in_grid, er[i]);
      end
    end
    turns_left = 5'd0;
  endtask

  task automatic test_lose();
    do_reset();
    sprite_row = 4'd0; sprite_col = 4'd0;
    lose = 1'b1;
    show(121, 45);
    checks++;
    if (rgb !== 12'h400) begin
      errors++;
      $display("FAIL lose_cursor_cell: rgb=%h, required 400", rgb);
    end
    show(300, 300);
    checks++;
    if (rgb !== 12'h400) begin
      errors++;
      $display("FAIL lose_unknown: rgb=%h, required 400", rgb);
    end
    lose = 1'b0;
    win = 1'b1;
    show(121, 45);
    checks++;
    if (rgb !== 12'h008) begin
      errors++;
      $display("FAIL win_no_cursor: rgb=%h, required 008", rgb);
    end
    win = 1'b0;
    sprite_row = 4'd12;
    show(121, 45);
    checks++;
    if (rgb !== 12'h008) begin
      errors++;
      $display("FAIL offboard_cursor: rgb=%h, required 008", rgb);
    end
    sprite_row = 4'd9; sprite_col = 4'd9;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_status();
    test_grid_lines();
    test_cursor();
    test_bar();
    test_lose();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
